// File: rtl/mips_cpu_pc.sv
// mips_cpu_pc
//   Program counter and branch-delay-slot sequencer for a MIPS I core.
//   - It holds the PC of the instruction being decoded.
//   - A taken branch or jump commits after exactly one delay-slot instruction.
//   - A redirect to HALT_ADDR stops the core after its delay slot has executed.
//   - A misaligned JR/JALR target stops the core at once and sets a sticky error flag.
// Ports
//   clk       rising-edge clock
//   reset     synchronous active-high reset (overrides stall)
//   stall     hold all state this cycle
//   CtrlPC    0 seq, 1 taken branch, 2 J/JAL, 3 JR/JALR
//   Instr     instruction at pc (branch offset [15:0], jump index [25:0])
//   rs_data   rs register value, JR/JALR target
//   pc        current instruction / fetch address
//   pc_plus8  link value (pc + 8)
//   in_delay  instruction at pc sits in a delay slot
//   active    core running
//   addr_err  sticky misaligned jump-register target
module mips_cpu_pc #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  CtrlPC,
  input  logic [31:0] Instr,
  input  logic [31:0] rs_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus8,
  output logic        in_delay,
  output logic        active,
  output logic        addr_err
);

  typedef enum logic {SEQ = 1'b0, DELAY = 1'b1} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_target, w_target_nxt;
  logic        r_active, w_active_nxt;
  logic        r_addr_err, w_addr_err_nxt;

  logic        w_adv;
  logic [31:0] w_pc4;
  logic [31:0] w_target;
  logic        w_misaligned;
  logic [5:0]  w_unused_instr;

  assign w_unused_instr = Instr[31:26];

  assign w_adv        = r_active & ~stall;
  assign w_pc4        = r_pc + 32'd4;
  assign w_misaligned = (CtrlPC == 2'd3) && (rs_data[1:0] != 2'b00);

  // Redirect target of the instruction at pc; only consumed in SEQ.
  always_comb begin
    w_target = w_pc4;
    case (CtrlPC)
      2'd1:    w_target = w_pc4 + {{14{Instr[15]}}, Instr[15:0], 2'b00};
      2'd2:    w_target = {w_pc4[31:28], Instr[25:0], 2'b00};
      2'd3:    w_target = rs_data;
      default: w_target = w_pc4;
    endcase
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_target_nxt   = r_target;
    w_active_nxt   = r_active;
    w_addr_err_nxt = r_addr_err;
    if (w_adv) begin
      case (r_state)
        SEQ: begin
          if (w_misaligned) begin
            // Fault before any delay slot: freeze pc where it is.
            w_addr_err_nxt = 1'b1;
            w_active_nxt   = 1'b0;
          end else begin
            w_pc_nxt = w_pc4;
            if (CtrlPC != 2'd0) begin
              w_target_nxt = w_target;
              w_state_nxt  = DELAY;
            end
          end
        end
        DELAY: begin
          // Delay-slot CtrlPC is ignored; the first redirect wins.
          w_pc_nxt    = r_target;
          w_state_nxt = SEQ;
          if (r_target == HALT_ADDR) w_active_nxt = 1'b0;
        end
        default: w_state_nxt = SEQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= SEQ;
      r_pc       <= RESET_VECTOR;
      r_target   <= '0;
      r_active   <= 1'b1;
      r_addr_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_target   <= w_target_nxt;
      r_active   <= w_active_nxt;
      r_addr_err <= w_addr_err_nxt;
    end
  end

  assign pc       = r_pc;
  assign pc_plus8 = r_pc + 32'd8;
  assign in_delay = (r_state == DELAY);
  assign active   = r_active;
  assign addr_err = r_addr_err;

endmodule
